// File: rtl/s100_bus_cycle_seq.sv
// s100_bus_cycle_seq: sequences one S-100 bus cycle (T1..T4) per accepted request, with wait states and timeout
module s100_bus_cycle_seq #(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic        pll0_2MHz,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        F_in_sdsb,
    input  logic        F_in_cdsb,
    input  logic        s100_RDY,
    input  logic [7:0]  s100_DI,
    output logic [15:0] S100adr0_15,
    output logic [3:0]  S100adr16_19,
    output logic [7:0]  s100_DO,
    output logic        s100_pSYNC,
    output logic        s100_pSTVAL,
    output logic        s100_pDBIN,
    output logic        s100_n_pWR,
    output logic        s100_sMEMR,
    output logic        s100_sMWRT,
    output logic        s100_sINP,
    output logic        s100_sOUT
);
    typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

    localparam logic [7:0] WS = 8'(WAIT_STATES);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_wr;
    logic       w_accept;

    assign req_ready = (r_state == IDLE) && !F_in_sdsb && !F_in_cdsb;
    assign w_accept  = req_valid && req_ready;

    // Bus cycle FSM; every bus pin and response field is a register updated here
    always_ff @(posedge pll0_2MHz) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_wr         <= 1'b0;
            S100adr0_15  <= 16'h0000;
            S100adr16_19 <= 4'h0;
            s100_DO      <= 8'h00;
            s100_pSYNC   <= 1'b0;
            s100_pSTVAL  <= 1'b1;
            s100_pDBIN   <= 1'b0;
            s100_n_pWR   <= 1'b1;
            s100_sMEMR   <= 1'b0;
            s100_sMWRT   <= 1'b0;
            s100_sINP    <= 1'b0;
            s100_sOUT    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= T1;
                        r_wr         <= req_type[0];
                        S100adr0_15  <= req_type[1] ? {req_addr[7:0], req_addr[7:0]} : req_addr[15:0];
                        S100adr16_19 <= req_type[1] ? 4'h0 : {req_addr[16], req_addr[17], req_addr[18], req_addr[19]};
                        s100_DO      <= req_type[0] ? req_wdata : s100_DO;
                        s100_sMEMR   <= req_type == 2'b00;
                        s100_sMWRT   <= req_type == 2'b01;
                        s100_sINP    <= req_type == 2'b10;
                        s100_sOUT    <= req_type == 2'b11;
                        s100_pSYNC   <= 1'b1;
                    end
                end
                T1: begin
                    r_state     <= T2;
                    s100_pSTVAL <= 1'b0;
                end
                T2: begin
                    r_state     <= T3;
                    r_cnt       <= 8'd1;
                    s100_pSYNC  <= 1'b0;
                    s100_pSTVAL <= 1'b1;
                    s100_pDBIN  <= !r_wr;
                    s100_n_pWR  <= !r_wr;
                end
                T3: begin
                    if (r_cnt > WS && s100_RDY) begin
                        r_state    <= T4;
                        s100_pDBIN <= 1'b0;
                        s100_n_pWR <= 1'b1;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= r_wr ? 8'h00 : s100_DI;
                        rsp_err    <= 1'b0;
                    end else if (r_cnt == TO) begin
                        r_state    <= T4;
                        s100_pDBIN <= 1'b0;
                        s100_n_pWR <= 1'b1;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= 8'hFF;
                        rsp_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                T4: begin
                    r_state    <= IDLE;
                    s100_sMEMR <= 1'b0;
                    s100_sMWRT <= 1'b0;
                    s100_sINP  <= 1'b0;
                    s100_sOUT  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s100_bus_cycle_seq.sv
// tb_s100_bus_cycle_seq: directed and random bus cycles checked cycle by cycle against a timeline model
module tb_s100_bus_cycle_seq;
    localparam int W  = 2;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [19:0] req_addr = 20'h0;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        F_in_sdsb = 1'b0;
    logic        F_in_cdsb = 1'b0;
    logic        s100_RDY = 1'b1;
    logic [7:0]  s100_DI = 8'h00;
    logic [15:0] S100adr0_15;
    logic [3:0]  S100adr16_19;
    logic [7:0]  s100_DO;
    logic        s100_pSYNC, s100_pSTVAL, s100_pDBIN, s100_n_pWR;
    logic        s100_sMEMR, s100_sMWRT, s100_sINP, s100_sOUT;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_adr = 16'h0;
    logic [3:0]  m_adr_hi = 4'h0;
    logic [7:0]  m_do = 8'h00;

    always #5 clk = ~clk;

    s100_bus_cycle_seq #(.WAIT_STATES(W), .TIMEOUT(TO)) dut (
        .pll0_2MHz(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .F_in_sdsb(F_in_sdsb), .F_in_cdsb(F_in_cdsb),
        .s100_RDY(s100_RDY), .s100_DI(s100_DI),
        .S100adr0_15(S100adr0_15), .S100adr16_19(S100adr16_19), .s100_DO(s100_DO),
        .s100_pSYNC(s100_pSYNC), .s100_pSTVAL(s100_pSTVAL), .s100_pDBIN(s100_pDBIN), .s100_n_pWR(s100_n_pWR),
        .s100_sMEMR(s100_sMEMR), .s100_sMWRT(s100_sMWRT), .s100_sINP(s100_sINP), .s100_sOUT(s100_sOUT)
    );

    function automatic logic [37:0] obs();
        return {S100adr0_15, S100adr16_19, s100_DO, s100_pSYNC, s100_pSTVAL, s100_pDBIN, s100_n_pWR,
                s100_sMEMR, s100_sMWRT, s100_sINP, s100_sOUT, rsp_valid, req_ready};
    endfunction

    function automatic logic [37:0] exp_vec(input logic sync, input logic stval, input logic dbin,
                                            input logic npwr, input logic [3:0] st, input logic rv, input logic rr);
        return {m_adr, m_adr_hi, m_do, sync, stval, dbin, npwr, st, rv, rr};
    endfunction

    task automatic check_vec(input string tag, input logic [37:0] e);
        checks++;
        assert (obs() === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs(), e);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [8:0] e);
        checks++;
        assert ({rsp_rdata, rsp_err} === e) else begin
            errors++;
            $error("FAIL %s: observed rdata/err %h expected %h", tag, {rsp_rdata, rsp_err}, e);
        end
    endtask

    // One request from an IDLE negedge; RDY is low for the first nlow strobe cycles, then high.
    task automatic run_cycle(input logic [1:0] t, input logic [19:0] a, input logic [7:0] wd,
                             input logic [7:0] di_last, input int nlow, input bit dis_t2);
        int len;
        bit err;
        bit wr;
        bit in_t3;
        logic [3:0] st;
        wr  = t[0];
        len = (nlow + 1 > W + 1) ? nlow + 1 : W + 1;
        err = len > TO;
        if (err) len = TO;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        #1;
        checks++;
        assert (req_ready === 1'b1) else begin
            errors++;
            $error("FAIL ready_before_accept: observed %b expected 1", req_ready);
        end
        m_adr    = t[1] ? {a[7:0], a[7:0]} : a[15:0];
        m_adr_hi = t[1] ? 4'h0 : {a[16], a[17], a[18], a[19]};
        if (wr) m_do = wd;
        for (int c = 0; c < len + 4; c++) begin
            @(negedge clk);
            in_t3 = (c >= 2) && (c <= len + 1);
            st    = (c <= len + 2) ? (4'b1000 >> t) : 4'b0000;
            check_vec($sformatf("cycle type%0d addr%05h c%0d", t, a, c),
                      exp_vec(c <= 1, c != 1, in_t3 && !wr, !(in_t3 && wr), st, c == len + 2, (c == len + 3) && !dis_t2));
            if (c == len + 2)
                check_rsp($sformatf("rsp type%0d addr%05h", t, a), {err ? 8'hFF : (wr ? 8'h00 : di_last), err});
            req_valid = (c < len + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_type  = 2'($urandom);
            req_addr  = 20'($urandom);
            req_wdata = 8'($urandom);
            if (dis_t2 && c == 1) F_in_sdsb = 1'b1;
            s100_RDY = in_t3 ? (c - 1 > nlow) : 1'($urandom_range(0, 1));
            s100_DI  = (c == len + 1) ? di_last : 8'($urandom);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_vec("reset_state", exp_vec(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1));
        check_rsp("reset_rsp", 9'h000);
        reset = 1'b0;
        @(negedge clk);

        run_cycle(2'b00, 20'h12345, 8'h00, 8'hA5, 0, 1'b0);
        run_cycle(2'b11, 20'h0003F, 8'h5A, 8'h77, 0, 1'b0);
        run_cycle(2'b01, 20'hABCDE, 8'hC3, 8'h11, 5, 1'b0);
        run_cycle(2'b10, 20'h00081, 8'h00, 8'h3C, 1, 1'b0);
        run_cycle(2'b00, 20'hFFFFF, 8'h00, 8'h99, 19, 1'b0);
        run_cycle(2'b01, 20'h80001, 8'h42, 8'h24, 100, 1'b0);
        run_cycle(2'b00, 20'h54321, 8'h00, 8'h66, 20, 1'b0);

        F_in_sdsb = 1'b1;
        req_valid = 1'b1;
        req_type  = 2'b00;
        req_addr  = 20'h11111;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                F_in_sdsb = 1'b0;
                F_in_cdsb = 1'b1;
            end
            #1;
            check_vec($sformatf("disabled_idle %0d", i), exp_vec(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0));
            @(negedge clk);
        end
        F_in_cdsb = 1'b0;
        req_valid = 1'b0;

        run_cycle(2'b10, 20'h12342, 8'h00, 8'h5E, 0, 1'b1);
        F_in_sdsb = 1'b0;
        run_cycle(2'b11, 20'h000C7, 8'hE1, 8'h00, 3, 1'b0);

        req_type  = 2'b00;
        req_addr  = 20'h5A5A5;
        req_valid = 1'b1;
        m_adr     = 16'hA5A5;
        m_adr_hi  = 4'b1010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s100_RDY = 1'b0;
        check_vec("read_in_t3", exp_vec(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0));
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        s100_RDY = 1'b1;
        m_adr    = 16'h0;
        m_adr_hi = 4'h0;
        m_do     = 8'h00;
        check_vec("reset_in_t3", exp_vec(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1));
        check_rsp("reset_in_t3_rsp", 9'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_vec($sformatf("after_reset %0d", i), exp_vec(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1));
        end
        run_cycle(2'b00, 20'h0BEEF, 8'h00, 8'hC0, 0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_cycle(2'($urandom), 20'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 24)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/s100_bus_cycle_seq.md
# s100_bus_cycle_seq

Sequences single S-100 bus cycles on the FPGA SBC. It accepts one memory-read, memory-write, I/O-in or I/O-out request at a time from an internal requester (CPU core or debug engine). It then drives address, status, data-out and the pSYNC/pSTVAL/pDBIN/pWR strobes in the correct T-state order, honouring RDY wait states and a timeout. It sits between the requester and the S-100 address/data/status/control output pins, whose buffers are enabled elsewhere.

## Interface
- WAIT_STATES, 0, minimum extra strobe cycles inserted in every cycle (0–15)
- TIMEOUT, 255, maximum strobe cycles before abort (WAIT_STATES+1 .. 255)

- pll0_2MHz  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_type  in  2  00 mem read, 01 mem write, 10 I/O in, 11 I/O out
- req_addr  in  20  A19..A0 (I/O uses [7:0] only)
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- F_in_sdsb, F_in_cdsb  in  1 each  bus disable inputs, active-high
- s100_RDY  in  1  slave ready, 0 = wait
- s100_DI  in  8  S-100 data-in bus
- S100adr0_15  out  16  A15..A0
- S100adr16_19  out  4  bit 0 = A19 … bit 3 = A16 (board wiring reversed)
- s100_DO  out  8  data-out bus
- s100_pSYNC, s100_pSTVAL, s100_pDBIN, s100_n_pWR  out  1 each  bus strobes (pSTVAL and n_pWR active-low)
- s100_sMEMR, s100_sMWRT, s100_sINP, s100_sOUT  out  1 each  status lines

## Operation
- All bus outputs and rsp_* are registered. req_ready is combinational: state==IDLE && !F_in_sdsb && !F_in_cdsb.
- Reset values:
  - Address 0, DO 0.
  - pSYNC 0, pSTVAL 1, pDBIN 0, n_pWR 1.
  - All status 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - State IDLE.
- A request is accepted on any edge where req_valid && req_ready. Type, address and data are latched there.
- States:
  - IDLE: strobes inactive, status 0. Address/DO hold their last values. On accept, go to T1.
  - T1 (1 cycle): drive address, DO (writes only; reads hold the old DO) and status; pSYNC=1.
  - T2 (1 cycle): pSYNC=1, pSTVAL=0.
  - T3 (strobe): pSYNC=0, pSTVAL=1. pDBIN=1 for reads/I/O in; n_pWR=0 for writes/I/O out. The strobe counter counts cycles spent in T3, starting at 1.
    - Exit to T4 when counter > WAIT_STATES and s100_RDY=1 in the same cycle. s100_DI is captured on that edge.
    - Otherwise, if counter == TIMEOUT, exit to T4 with err=1 and rdata=0xFF.
  - T4 (1 cycle): strobes inactive, address/status still held. rsp_valid=1 with rdata/err. Next state is IDLE, where status clears.
- Status: sMEMR for mem read, sMWRT for mem write, sINP for I/O in, sOUT for I/O out. Each is asserted from T1 through T4 inclusive.
- I/O address: A7..A0 = req_addr[7:0], A15..A8 = req_addr[7:0] (duplicated), A19..A16 = 0.
- Write cycles set rsp_rdata=0. Non-error cycles set rsp_err=0.
- Bus disable is sampled only in IDLE. A disable asserted mid-cycle does not abort the cycle; the next request is held off.
- s100_RDY is ignored outside T3.
- Reset in any state returns all outputs to reset values on the next edge. An in-flight cycle is dropped with no rsp_valid.

## Timing
- Accept at edge k. T1 occupies k→k+1, T2 k+1→k+2, and T3 starts at k+2.
- With RDY=1: T3 lasts WAIT_STATES+1 cycles, and rsp_valid is high in cycle k+3+WAIT_STATES+1.
- Each low-RDY cycle after the minimum adds one T3 cycle.
- Minimum cycle is 4+WAIT_STATES clocks, plus one IDLE clock before the next accept. Maximum throughput is one cycle per 5+WAIT_STATES clocks.
- s100_DI is sampled on the final T3 edge.
- rsp_valid is exactly one clock wide.

## Test plan
- Mem read, WAIT_STATES=0, RDY=1, addr 0x12345, DI=0xA5:
  - T1: S100adr0_15=0x2345, S100adr16_19=4'b1000, sMEMR=1, pSYNC=1.
  - T2: pSTVAL=0.
  - T3: pDBIN=1 for 1 cycle.
  - T4: rsp_valid with rdata 0xA5, err 0.
  - 4 cycles from accept to response.
- I/O out, addr 0x3F, wdata 0x5A, WAIT_STATES=2 → S100adr0_15=0x3F3F, A19..A16=0, sOUT=1, DO=0x5A, n_pWR=0 for exactly 3 cycles; rsp_rdata=0, err=0.
- Mem write, WAIT_STATES=0, RDY low for 5 T3 cycles then high → n_pWR=0 for 6 cycles; sMWRT held T1..T4.
- RDY stuck low, TIMEOUT=20 → T3 lasts exactly 20 cycles, then rsp_valid with err=1, rdata=0xFF, then IDLE.
- F_in_sdsb=1 with req_valid=1 → req_ready=0, no strobes. Raising F_in_sdsb in T2 of an active cycle → cycle completes normally.
- Reset asserted in T3 of a read → next cycle: pDBIN=0, pSTVAL=1, status 0, address 0, no rsp_valid. The next request is accepted normally.
